// File: rtl/child_event_collector.sv
// child_event_collector: turns level changes on a replicated child array's
// outputs into a serial stream of (child index, new level) events. Changes
// are latched as pending per child and granted round-robin into a single
// registered valid/ready output stage.
module child_event_collector #(
    parameter int unsigned NUM_CHILDREN = 8,
    parameter int unsigned IDX_W        = $clog2(NUM_CHILDREN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CHILDREN-1:0] in,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [IDX_W-1:0]        evt_idx,
    output logic                    evt_level,
    output logic [NUM_CHILDREN-1:0] overflow,
    input  logic                    ovf_clr
);

    localparam int unsigned N = NUM_CHILDREN;

    logic [N-1:0]     in_q;
    logic [N-1:0]     pend;
    logic [N-1:0]     lvl;
    logic [N-1:0]     chg;
    logic [N-1:0]     gnt;
    logic [N-1:0]     ovf_set;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_found;
    logic             out_free;
    logic             grant;
    int unsigned      scan;

    // Edge detect against the previous sample of every child
    assign chg = in ^ in_q;

    // Output stage may load a new event when empty or being drained this edge
    assign out_free = !evt_valid || evt_ready;
    assign grant    = out_free && grant_found;

    // Round-robin search over registered pend, starting at ptr and wrapping
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = 0;
        for (int unsigned k = 0; k < N; k++) begin
            scan = 32'(ptr) + k;
            if (scan >= N) begin
                scan = scan - N;
            end
            if (!grant_found && pend[scan[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan[IDX_W-1:0];
            end
        end
    end

    // Next start point sits just past the winner, wrapping at the last child
    always_comb begin
        ptr_nxt = grant_idx + IDX_W'(1);
        if (32'(grant_idx) == N - 1) begin
            ptr_nxt = '0;
        end
    end

    // Per-child grant strobe and lost-event detection
    always_comb begin
        gnt     = '0;
        ovf_set = '0;
        for (int unsigned i = 0; i < N; i++) begin
            gnt[i]     = grant && (grant_idx == IDX_W'(i));
            ovf_set[i] = chg[i] && pend[i] && !gnt[i];
        end
    end

    // Previous-sample register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q <= '0;
        end else begin
            in_q <= in;
        end
    end

    // Pending flags and latest level; a fresh change always re-arms pend
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            lvl  <= '0;
        end else begin
            pend <= chg | (pend & ~gnt);
            lvl  <= (lvl & ~chg) | (in & chg);
        end
    end

    // Registered event output and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_idx   <= '0;
            evt_level <= 1'b0;
            ptr       <= '0;
        end else if (grant) begin
            evt_valid <= 1'b1;
            evt_idx   <= grant_idx;
            evt_level <= lvl[grant_idx];
            ptr       <= ptr_nxt;
        end else if (out_free) begin
            evt_valid <= 1'b0;
        end
    end

    // Sticky overflow; a new loss on the clear edge keeps its bit set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= '0;
        end else if (ovf_clr) begin
            overflow <= ovf_set;
        end else begin
            overflow <= overflow | ovf_set;
        end
    end

endmodule

// File: tb/tb_child_event_collector.sv
// Bench for child_event_collector: directed stimulus with a scoreboard of
// expected (idx, level) events checked at every accepted handshake.
module tb_child_event_collector;

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = 3;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     in;
    logic             evt_valid;
    logic             evt_ready;
    logic [IDX_W-1:0] evt_idx;
    logic             evt_level;
    logic [N-1:0]     overflow;
    logic             ovf_clr;

    int total;
    int bad;

    logic [IDX_W:0] exp_q[$];

    child_event_collector #(.NUM_CHILDREN(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_idx   (evt_idx),
        .evt_level (evt_level),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input logic level);
        exp_q.push_back({IDX_W'(idx), level});
    endtask

    // Run until the scoreboard is empty and the output stage is idle
    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && !evt_valid) break;
            cyc();
        end
        check("drain_q", 32'(exp_q.size()), 0);
        check("drain_valid", 32'(evt_valid), 0);
    endtask

    // Handshake monitor: sampled mid-cycle, the edge that follows accepts
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                check("unexp_evt", 32'({evt_idx, evt_level}), 32'hFFFF);
            end else begin
                check("evt", 32'({evt_idx, evt_level}), 32'(exp_q.pop_front()));
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in        = '0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;

        // Reset state
        cyc();
        cyc();
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_idx", 32'(evt_idx), 0);
        check("rst_level", 32'(evt_level), 0);
        check("rst_ovf", 32'(overflow), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("idle_valid", 32'(evt_valid), 0);
        end

        // Burst: four rising children, one event per cycle in index order
        evt_ready = 1'b1;
        in = 8'hA5;
        push(0, 1'b1);
        push(2, 1'b1);
        push(5, 1'b1);
        push(7, 1'b1);
        cyc();
        check("burst_lat", 32'(evt_valid), 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("burst_valid", 32'(evt_valid), 1);
        end
        cyc();
        check("burst_end", 32'(evt_valid), 0);
        drain();

        // Single event: two-edge latency, valid for exactly one cycle
        in = 8'hAD;
        push(3, 1'b1);
        cyc();
        check("single_lat", 32'(evt_valid), 0);
        cyc();
        check("single_valid", 32'(evt_valid), 1);
        check("single_idx", 32'(evt_idx), 3);
        check("single_level", 32'(evt_level), 1);
        cyc();
        check("single_once", 32'(evt_valid), 0);
        drain();

        // Stall stability with overflow on a child toggling behind the held event
        evt_ready = 1'b0;
        in = 8'hBD;
        push(4, 1'b1);
        cyc();
        cyc();
        for (int s = 0; s < 5; s++) begin
            check("stall_valid", 32'(evt_valid), 1);
            check("stall_idx", 32'(evt_idx), 4);
            check("stall_level", 32'(evt_level), 1);
            if (s == 0) in = 8'hBF;
            if (s == 2) in = 8'hBD;
            cyc();
        end
        check("ovf_set", 32'(overflow), 32'h02);
        push(1, 1'b0);
        evt_ready = 1'b1;
        cyc();
        check("after_stall_valid", 32'(evt_valid), 1);
        check("after_stall_idx", 32'(evt_idx), 1);
        check("after_stall_level", 32'(evt_level), 0);
        drain();
        check("ovf_sticky", 32'(overflow), 32'h02);
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 0);

        // Round-robin wrap: after granting 6, child 7 precedes child 0
        in = 8'hFD;
        push(6, 1'b1);
        drain();
        in = 8'h7C;
        push(7, 1'b0);
        push(0, 1'b0);
        cyc();
        cyc();
        check("wrap_first", 32'(evt_idx), 7);
        cyc();
        check("wrap_second", 32'(evt_idx), 0);
        drain();

        // Mid-stream reset with a held event and more pending
        evt_ready = 1'b0;
        in = 8'h72;
        cyc();
        cyc();
        check("pre_rst_valid", 32'(evt_valid), 1);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(evt_valid), 0);
        check("mrst_idx", 32'(evt_idx), 0);
        check("mrst_level", 32'(evt_level), 0);
        check("mrst_ovf", 32'(overflow), 0);
        in = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        evt_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("post_rst_idle", 32'(evt_valid), 0);
        end
        check("final_q", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/child_event_collector.md
# child_event_collector

Gathers the per-child output vector of a replicated child array back into a single event stream. Each cycle it compares the child outputs with their previously sampled values, records each change as a pending event, and emits one event at a time as (child index, new level) over a valid/ready handshake using round-robin arbitration. It sits at the return side of the child array, between the children's outputs and a single downstream consumer.

## Interface

Parameters:
- NUM_CHILDREN, default 8: number of child lanes, minimum 2.
- IDX_W, default $clog2(NUM_CHILDREN): index width. It is derived and must not be overridden.

Ports:
- clk, input, 1: single clock. All logic is rising-edge.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- in, input, NUM_CHILDREN: child outputs, one bit per child. Synchronous to clk.
- evt_valid, output, 1: event available.
- evt_ready, input, 1: consumer accepts the event on an edge where evt_valid=1.
- evt_idx, output, IDX_W: child index of the event.
- evt_level, output, 1: new value of in[evt_idx].
- overflow, output, NUM_CHILDREN: sticky per child. Set when an event on that child is lost.
- ovf_clr, input, 1: clears all overflow bits.

## Operation

State:
- in_q[N]: previous sample of in.
- pend[N]: pending events.
- lvl[N]: latest level per child.
- ptr[IDX_W]: round-robin start index.
- Output register: evt_valid, evt_idx, evt_level.
- overflow[N].

Change detection:
- chg[i] = in[i] ^ in_q[i].
- in_q <= in every edge.
- in_q resets to 0, so a child already high at reset release produces a rising event.

Pending update, per child i, each edge:
- If chg[i]: pend[i] <= 1 and lvl[i] <= in[i].
- If chg[i], pend[i] is already 1, and i is not being granted this edge: overflow[i] <= 1. The newest level replaces the older one; only one event remains pending.
- If i is granted this edge and chg[i]=0: pend[i] <= 0.
- If i is granted and chg[i]=1 on the same edge: pend[i] stays 1 with the new level. No overflow.

Arbitration and output:
- The output register is free when evt_valid=0, or when evt_valid=1 and evt_ready=1.
- When free and any pend bit is set, grant the first set bit searching ptr, ptr+1, …, wrapping modulo NUM_CHILDREN.
- On a grant: evt_valid <= 1, evt_idx <= g, evt_level <= lvl[g], ptr <= (g+1) mod NUM_CHILDREN.
- When free and no pend bit is set: evt_valid <= 0.
- evt_idx and evt_level are held stable while evt_valid=1 and evt_ready=0.
- Arbitration uses registered pend only. A change detected on an edge can be granted at the earliest on the next edge.

Overflow clearing:
- ovf_clr=1 clears every overflow bit on the edge.
- If a new overflow on child i occurs on the same edge, the set wins for bit i.

Reset values:
- evt_valid=0, evt_idx=0, evt_level=0, overflow=0.
- in_q=0, pend=0, lvl=0, ptr=0.
- An asserted rst_n mid-transfer discards all pending events and the held output immediately. No event is emitted after reset release unless in differs from 0.

## Timing

- Latency: in[i] changes before edge k. pend[i] is set at edge k. evt_valid=1 with evt_idx=i after edge k+1 (2 edges), provided the output register is free and i wins arbitration.
- Throughput: one event per cycle while evt_ready=1 is held continuously.
- Consumer contract: evt_ready may be held high while evt_valid=0. evt_valid never depends combinationally on evt_ready. There are no combinational paths from inputs to outputs.
- Worst-case wait for a pending child under continuous ready: NUM_CHILDREN-1 grants.
- Wrap: ptr = NUM_CHILDREN-1 followed by a grant gives ptr = 0.

## Test plan

- **Reset:** drive rst_n=0 mid-stream with ready=0 and 3 events pending. All outputs go to 0 immediately. After release with in=0, evt_valid stays 0 for 10 cycles.
- **Single event:** ready=1, in 0→8'h08 before edge k. evt_valid=1 after edge k+1 with idx=3 and level=1, for exactly one cycle.
- **Burst:** ready=1, in 0→8'hA5 in one cycle. Events appear on consecutive cycles as idx 0, 2, 5, 7, each with level=1. Then evt_valid=0.
- **Backpressure and overflow:** ready=0, in[1] toggles 0→1, then back to 0 two cycles later. overflow=8'h02. Raising ready produces exactly one event: idx=1, level=0. Pulsing ovf_clr then clears overflow to 0.
- **Round-robin wrap:** grant idx 6 first, then make pend bits 0 and 7 set together. The next events are idx 7, then idx 0.
- **Stall stability:** valid with idx=4 and ready=0 for 5 cycles while other children toggle. idx and level stay constant. The held event is accepted on the first cycle ready=1.
